// File: rtl/mem_port_arbiter.sv
// Shares one backend memory port between instruction fetch and the LSU.
// Owner is latched in IDLE; a single transaction is in flight at a time.
module mem_port_arbiter #(
  parameter int INDEX_WIDTH = 64,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   if_req_valid,
  output logic                   if_req_ready,
  input  logic [INDEX_WIDTH-1:0] if_req_index,
  input  logic                   if_flush,
  output logic                   if_done,
  output logic [DATA_WIDTH-1:0]  if_rdata,
  input  logic                   opload_index_valid,
  output logic                   opload_index_ready,
  input  logic [INDEX_WIDTH-1:0] opload_index,
  output logic                   opload_operation_done,
  output logic [DATA_WIDTH-1:0]  opload_read_data,
  input  logic                   opstore_index_valid,
  output logic                   opstore_index_ready,
  input  logic [INDEX_WIDTH-1:0] opstore_index,
  input  logic [DATA_WIDTH-1:0]  opstore_write_data,
  input  logic [DATA_WIDTH-1:0]  opstore_write_mask,
  output logic                   opstore_operation_done,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [INDEX_WIDTH-1:0] mem_req_index,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  output logic [DATA_WIDTH-1:0]  mem_req_wmask,
  input  logic                   mem_rsp_done,
  input  logic [DATA_WIDTH-1:0]  mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT, OUTSTANDING} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

  state_t state, state_next;
  owner_t owner, owner_next;
  logic   rr_lsu, rr_lsu_next;
  logic   squash, squash_next;
  logic   fetch_req, lsu_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= OWN_NONE;
      rr_lsu <= 1'b1;
      squash <= 1'b0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      rr_lsu <= rr_lsu_next;
      squash <= squash_next;
    end
  end

  always_comb begin
    state_next             = state;
    owner_next             = owner;
    rr_lsu_next            = rr_lsu;
    squash_next            = squash;
    if_req_ready           = 1'b0;
    if_done                = 1'b0;
    if_rdata               = '0;
    opload_index_ready     = 1'b0;
    opload_operation_done  = 1'b0;
    opload_read_data       = '0;
    opstore_index_ready    = 1'b0;
    opstore_operation_done = 1'b0;
    mem_req_valid          = 1'b0;
    mem_req_write          = 1'b0;
    mem_req_index          = '0;
    mem_req_wdata          = '0;
    mem_req_wmask          = '0;
    fetch_req              = if_req_valid & ~if_flush;
    lsu_req                = opload_index_valid | opstore_index_valid;

    case (state)
      IDLE: begin
        if (fetch_req || lsu_req) begin
          state_next = GRANT;
          if (fetch_req && (!lsu_req || !rr_lsu))
            owner_next = OWN_FETCH;
          else
            owner_next = opload_index_valid ? OWN_LOAD : OWN_STORE;
        end
      end

      GRANT: begin
        case (owner)
          OWN_FETCH: begin
            mem_req_index = if_req_index;
            // A flush abandons the fetch before it can fire.
            if (if_flush) begin
              state_next = IDLE;
              owner_next = OWN_NONE;
            end else begin
              mem_req_valid = if_req_valid;
              if_req_ready  = mem_req_ready;
            end
          end
          OWN_LOAD: begin
            mem_req_valid      = opload_index_valid;
            mem_req_index      = opload_index;
            opload_index_ready = mem_req_ready;
          end
          OWN_STORE: begin
            mem_req_valid       = opstore_index_valid;
            mem_req_write       = 1'b1;
            mem_req_index       = opstore_index;
            mem_req_wdata       = opstore_write_data;
            mem_req_wmask       = opstore_write_mask;
            opstore_index_ready = mem_req_ready;
          end
          default: begin
            state_next = IDLE;
            owner_next = OWN_NONE;
          end
        endcase
        if (mem_req_valid && mem_req_ready)
          state_next = OUTSTANDING;
      end

      OUTSTANDING: begin
        if (mem_rsp_done) begin
          case (owner)
            OWN_FETCH: begin
              if (!(squash || if_flush)) begin
                if_done  = 1'b1;
                if_rdata = mem_rsp_rdata;
              end
            end
            OWN_LOAD: begin
              opload_operation_done = 1'b1;
              opload_read_data      = mem_rsp_rdata;
            end
            OWN_STORE: opstore_operation_done = 1'b1;
            default: ;
          endcase
          state_next  = IDLE;
          owner_next  = OWN_NONE;
          squash_next = 1'b0;
          rr_lsu_next = (owner == OWN_FETCH);
        end else if (owner == OWN_FETCH && if_flush) begin
          squash_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single backend memory port between the instruction-fetch read requester and the mem-stage load/store requester.
- Arbitrates between requesters and forwards the winner's request downstream.
- Tracks the single outstanding transaction and routes the completion (done + read data) back to its owner.
- Sits between fetch/mem stages and the memory/bus interface; supports fetch flush while fetch owns the port.

Parameters:
INDEX_WIDTH, 64, width of request index (word index, address >> 3)
DATA_WIDTH, 64, width of read/write data and write mask

Ports:
clock  input  1  clock
reset_n  input  1  asynchronous active-low reset
if_req_valid  input  1  fetch read request
if_req_ready  output  1  fetch request accepted downstream
if_req_index  input  INDEX_WIDTH  fetch word index
if_flush  input  1  fetch flush; abandon or squash the fetch transaction
if_done  output  1  fetch read complete pulse
if_rdata  output  DATA_WIDTH  fetch read data, valid with if_done
opload_index_valid  input  1  mem-stage load request
opload_index_ready  output  1  load accepted
opload_index  input  INDEX_WIDTH  load word index
opload_operation_done  output  1  load complete pulse
opload_read_data  output  DATA_WIDTH  load data, valid with done
opstore_index_valid  input  1  mem-stage store request
opstore_index_ready  output  1  store accepted
opstore_index  input  INDEX_WIDTH  store word index
opstore_write_data  input  DATA_WIDTH  store data, pre-shifted
opstore_write_mask  input  DATA_WIDTH  bit mask
opstore_operation_done  output  1  store complete pulse
mem_req_valid  output  1  downstream request valid
mem_req_ready  input  1  downstream accepts request
mem_req_write  output  1  1 = store, 0 = read
mem_req_index  output  INDEX_WIDTH  downstream index
mem_req_wdata  output  DATA_WIDTH  downstream write data
mem_req_wmask  output  DATA_WIDTH  downstream write mask
mem_rsp_done  input  1  downstream transaction complete, one-cycle pulse
mem_rsp_rdata  input  DATA_WIDTH  downstream read data, valid with done

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clock.
- Reset values:
  - state = IDLE.
  - Owner = none.
  - Round-robin pointer = LSU (LSU wins the first tie).
  - squash = 0.
  - All outputs 0.
- Requester rules:
  - Every requester holds valid and payload stable until its ready is seen.
  - At most one transaction is outstanding system-wide.
  - LSU load and store are mutually exclusive. If both are asserted, load wins and store is not granted.
- FSM states: IDLE, GRANT, OUTSTANDING.
- IDLE:
  - No downstream valid.
  - If any request is present, latch the owner (FETCH or LSU) and go to GRANT next cycle.
  - Single requester: that requester wins.
  - Both requesting: the round-robin pointer's target wins.
  - A fetch request with if_flush high that same cycle is ignored.
- GRANT:
  - mem_req_* is a combinational passthrough of the owner's payload.
  - mem_req_write = 1 only for an LSU store.
  - The owner's ready = mem_req_ready; all other readys are 0.
  - Fire (valid & ready) -> OUTSTANDING.
  - If owner is FETCH and if_flush is high before fire: no fire that cycle (mem_req_valid forced 0), return to IDLE.
  - If the owner drops valid, mem_req_valid follows it. This is a protocol violation and is not checked.
- OUTSTANDING:
  - mem_req_valid = 0.
  - On mem_rsp_done, pulse the owner's done in the same cycle with rdata passed through.
  - Then go to IDLE, clear the owner, and set the round-robin pointer to the non-owner.
- Fetch flush while OUTSTANDING with owner FETCH:
  - Set the squash flag.
  - On mem_rsp_done, if_done is suppressed; the response is still consumed and the state still returns to IDLE.
  - Squash clears on leaving OUTSTANDING.
- mem_rsp_done is ignored in IDLE/GRANT. A done arriving in the same cycle as fire does not count.
- Idle data outputs:
  - if_rdata and opload_read_data are 0 when their done is low.
  - mem_req_wdata/wmask are 0 unless a store is granted.
- Latency:
  - Request seen at cycle 0; grant in cycle 1, so the earliest fire is cycle 1.
  - Done returns the same cycle as mem_rsp_done.
  - Minimum back-to-back spacing: IDLE one cycle between transactions.
- Reset mid-operation: returns to IDLE and drops ownership. A stale mem_rsp_done after reset is ignored.

Test Plan:
- Lone LSU load, index 0x40, mem_req_ready = 1 at cycle 1, done at cycle 4 with rdata 0xDEADBEEF -> mem_req_valid at cycle 1, write = 0, opload_index_ready pulse at cycle 1, opload_operation_done pulse at cycle 4 with 0xDEADBEEF, if_done stays 0.
- Fetch and LSU store request together after reset -> LSU store granted first (write = 1, wmask 0xFF00 passed through). Fetch is granted in the next arbitration and wins the following tie (alternation verified over 4 transactions).
- Fetch granted, mem_req_ready held 0 for 3 cycles, then if_flush -> no fire, return to IDLE, a pending LSU request is granted next.
- Fetch OUTSTANDING, if_flush pulses, then mem_rsp_done -> if_done stays 0, state IDLE, next request is accepted normally.
- mem_rsp_done pulsed while IDLE, and in the same cycle as fire -> no done on any requester, FSM unaffected.
- Assert reset_n low while OUTSTANDING, then release and pulse mem_rsp_done -> all outputs 0, no done pulse, LSU wins the next tie.
